// File: rtl/tc_pkg.sv
`default_nettype none
// ============================================================================
// tc_pkg : shared constants, FSM encoding and helpers for the TC updater
// Rev 1.0
// ============================================================================
package tc_pkg;

  localparam logic [15:0] ETYPE_PTP     = 16'h98F7;
  localparam int          TS_OFS_DEF    = 11;
  localparam int          ETYPE_OFS_DEF = 12;
  localparam int          CF_OFS_DEF    = 22;
  localparam int          CF_BYTES      = 8;
  localparam int          LAT           = 9;
  localparam logic [6:0]  BYTE_CNT_MAX  = 7'd127;

  typedef enum logic [1:0] {
    IDLE_S = 2'd0,
    HDR_S  = 2'd1,
    CF_S   = 2'd2,
    PASS_S = 2'd3
  } tc_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tc_residence_calc.sv
`default_nettype none
// ============================================================================
// tc_residence_calc : wrap-aware residence, scaled to CF units, added to CF
// Rev 1.0
// ============================================================================
module tc_residence_calc #(
  parameter int              TS_W      = 19,
  parameter logic [TS_W-1:0] TIMER_MAX = TS_W'('h7A11F),
  parameter int              TICK_NS   = 8,
  parameter int              CF_SHIFT  = 16,
  parameter logic [31:0]     CF_ADJ    = 32'h0
) (
  input  logic [TS_W-1:0] timer_i,
  input  logic [TS_W-1:0] ts_i,
  input  logic [63:0]     cf_old_i,
  output logic [63:0]     cf_new_o
);

  localparam logic [TS_W:0] MODULUS = {1'b0, TIMER_MAX} + (TS_W+1)'(1);

  logic [TS_W:0] w_res;
  logic [63:0]   w_term;

  // CF_ADJ is sign-extended so a negative adjustment subtracts modulo 2^64
  always_comb begin
    if (timer_i >= ts_i) begin
      w_res = {1'b0, timer_i} - {1'b0, ts_i};
    end else begin
      w_res = {1'b0, timer_i} + MODULUS - {1'b0, ts_i};
    end
    w_term   = 64'(w_res) * 64'(TICK_NS) + {{32{CF_ADJ[31]}}, CF_ADJ};
    cf_new_o = cf_old_i + (w_term << CF_SHIFT);
  end

endmodule
`default_nettype wire

// File: rtl/tc_calc_param.sv
`default_nettype none
// ============================================================================
// tc_calc_param : PTP transparent-clock correctionField updater, 9-cycle delay
// Rev 1.0
// ============================================================================
module tc_calc_param
  import tc_pkg::*;
#(
  parameter int              TS_W      = 19,
  parameter logic [TS_W-1:0] TIMER_MAX = TS_W'('h7A11F),
  parameter int              TS_OFS    = TS_OFS_DEF,
  parameter int              ETYPE_OFS = ETYPE_OFS_DEF,
  parameter logic [15:0]     ETYPE_VAL = ETYPE_PTP,
  parameter int              CF_OFS    = CF_OFS_DEF,
  parameter int              TICK_NS   = 8,
  parameter int              CF_SHIFT  = 16,
  parameter logic [31:0]     CF_ADJ    = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [8:0]  iv_pkt_data,
  input  logic        i_pkt_data_wr,
  output logic [8:0]  ov_pkt_data,
  output logic        o_pkt_data_wr,
  input  logic        i_timer_rst,
  input  logic        i_tc_en,
  output logic [31:0] ov_tc_upd_cnt,
  output logic [31:0] ov_tc_err_cnt
);

  localparam int         HDR_END  = max_int(TS_OFS + 2, ETYPE_OFS + 1);
  localparam logic [6:0] IDX_TS0  = 7'(TS_OFS);
  localparam logic [6:0] IDX_TS1  = 7'(TS_OFS + 1);
  localparam logic [6:0] IDX_TS2  = 7'(TS_OFS + 2);
  localparam logic [6:0] IDX_ET0  = 7'(ETYPE_OFS);
  localparam logic [6:0] IDX_ET1  = 7'(ETYPE_OFS + 1);
  localparam logic [6:0] IDX_HDRE = 7'(HDR_END);
  localparam logic [6:0] IDX_CFL  = 7'(CF_OFS + CF_BYTES - 1);

  logic            w_wr;
  logic            w_sof;
  logic [7:0]      w_byte;
  logic [6:0]      w_idx;
  logic [6:0]      cnt_q, cnt_d;
  logic [TS_W-1:0] timer_q, timer_d;
  logic [TS_W-1:0] ts_q;
  logic [7:0]      etype_hi_q;
  logic            match_q;
  logic            w_match;
  logic [9:0]      dly_q [LAT];
  logic [63:0]     w_cf_old;
  logic [63:0]     w_cf_new;
  logic            w_cf_wr;
  tc_state_e       state_q;
  logic            en_q;
  logic [31:0]     upd_cnt_q;
  logic [31:0]     err_cnt_q;

  assign w_wr   = i_pkt_data_wr;
  assign w_sof  = i_pkt_data_wr & iv_pkt_data[8];
  assign w_byte = iv_pkt_data[7:0];
  assign w_idx  = w_sof ? 7'd0 : cnt_q;

  // The second EtherType byte may also be the last header byte, so compare live
  assign w_match = (w_idx == IDX_ET1) ? ({etype_hi_q, w_byte} == ETYPE_VAL) : match_q;
  assign w_cf_wr = (state_q == CF_S) && w_wr && !w_sof && (w_idx == IDX_CFL);

  always_comb begin
    timer_d = timer_q + TS_W'(1);
    if (i_timer_rst || (timer_q == TIMER_MAX)) begin
      timer_d = '0;
    end
    cnt_d = cnt_q;
    if (w_sof) begin
      cnt_d = 7'd1;
    end else if (w_wr && (cnt_q != BYTE_CNT_MAX)) begin
      cnt_d = cnt_q + 7'd1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      timer_q <= '0;
      cnt_q   <= '0;
    end else begin
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      ts_q       <= '0;
      etype_hi_q <= '0;
      match_q    <= 1'b0;
    end else if (w_wr) begin
      if (w_idx == IDX_TS0) ts_q[TS_W-1:16] <= w_byte[TS_W-17:0];
      if (w_idx == IDX_TS1) ts_q[15:8]      <= w_byte;
      if (w_idx == IDX_TS2) ts_q[7:0]       <= w_byte;
      if (w_idx == IDX_ET0) etype_hi_q      <= w_byte;
      if (w_idx == IDX_ET1) match_q         <= w_match;
    end
  end

  // Incoming byte is the CF LSB; the other seven CF bytes sit in stages 0..6
  always_comb begin
    w_cf_old      = '0;
    w_cf_old[7:0] = w_byte;
    for (int k = 1; k < CF_BYTES; k++) begin
      w_cf_old[8*k +: 8] = dly_q[k-1][7:0];
    end
  end

  tc_residence_calc #(
    .TS_W      (TS_W),
    .TIMER_MAX (TIMER_MAX),
    .TICK_NS   (TICK_NS),
    .CF_SHIFT  (CF_SHIFT),
    .CF_ADJ    (CF_ADJ)
  ) u_res (
    .timer_i  (timer_q),
    .ts_i     (ts_q),
    .cf_old_i (w_cf_old),
    .cf_new_o (w_cf_new)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int k = 0; k < LAT; k++) begin
        dly_q[k] <= '0;
      end
    end else begin
      dly_q[0] <= {w_wr, iv_pkt_data};
      for (int k = 1; k < LAT; k++) begin
        dly_q[k] <= dly_q[k-1];
      end
      if (w_cf_wr) begin
        for (int k = 0; k < CF_BYTES; k++) begin
          dly_q[k][7:0] <= w_cf_new[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= IDLE_S;
      en_q      <= 1'b0;
      upd_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE_S: begin
          if (w_sof) begin
            state_q <= HDR_S;
            en_q    <= i_tc_en;
          end
        end
        HDR_S, CF_S: begin
          if (!w_wr) begin
            err_cnt_q <= err_cnt_q + 32'd1;
            state_q   <= IDLE_S;
          end else if (w_sof) begin
            err_cnt_q <= err_cnt_q + 32'd1;
            en_q      <= i_tc_en;
            state_q   <= HDR_S;
          end else if ((state_q == HDR_S) && (w_idx == IDX_HDRE)) begin
            state_q <= (w_match && en_q) ? CF_S : PASS_S;
          end else if (w_cf_wr) begin
            upd_cnt_q <= upd_cnt_q + 32'd1;
            state_q   <= PASS_S;
          end
        end
        PASS_S: begin
          if (!w_wr) begin
            state_q <= IDLE_S;
          end else if (w_sof) begin
            en_q    <= i_tc_en;
            state_q <= HDR_S;
          end
        end
        default: state_q <= IDLE_S;
      endcase
    end
  end

  assign ov_pkt_data   = dly_q[LAT-1][8:0];
  assign o_pkt_data_wr = dly_q[LAT-1][9];
  assign ov_tc_upd_cnt = upd_cnt_q;
  assign ov_tc_err_cnt = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_tc_calc_param.sv
`default_nettype none
// ============================================================================
// tb_tc_calc_param : directed vector bench for the TC correctionField updater
// Rev 1.0
// ============================================================================
module tb_tc_calc_param;

  localparam int TS_OFS_TB = 14;
  localparam int CF_LAST   = 29;
  localparam int LOGN      = 16384;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [8:0]  din;
  logic        wr;
  logic        trst;
  logic        en;
  logic [8:0]  dout, dout2;
  logic        dwr, dwr2;
  logic [31:0] upd, err, upd2, err2;

  always #4 clk = ~clk;

  // Timestamp moved off the EtherType bytes so ts is freely choosable
  tc_calc_param #(.TS_OFS(TS_OFS_TB)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .iv_pkt_data(din), .i_pkt_data_wr(wr),
    .ov_pkt_data(dout), .o_pkt_data_wr(dwr), .i_timer_rst(trst), .i_tc_en(en),
    .ov_tc_upd_cnt(upd), .ov_tc_err_cnt(err)
  );

  tc_calc_param #(.TS_OFS(TS_OFS_TB), .TIMER_MAX(19'h3F), .TICK_NS(1), .CF_SHIFT(0)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .iv_pkt_data(din), .i_pkt_data_wr(wr),
    .ov_pkt_data(dout2), .o_pkt_data_wr(dwr2), .i_timer_rst(trst), .i_tc_en(en),
    .ov_tc_upd_cnt(upd2), .ov_tc_err_cnt(err2)
  );

  int         cyc = 0;
  logic [9:0] log1 [LOGN];
  logic [9:0] log2 [LOGN];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < LOGN) begin
      log1[cyc] <= {dwr, dout};
      log2[cyc] <= {dwr2, dout2};
    end
  end

  int n_run  = 0;
  int n_fail = 0;

  logic [7:0] tx_b  [64];
  logic [7:0] exp_b [64];

  typedef struct {
    logic [15:0] etype;
    logic [18:0] ts;
    int          tmr;
    logic [63:0] cf_old;
    bit          en_sof;
    bit          en_after;
    logic [63:0] cf_exp;
    int          upd;
    int          err;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_run++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic build(input logic [15:0] et, input logic [18:0] ts,
                       input logic [63:0] cf_old, input logic [63:0] cf_exp);
    for (int i = 0; i < 64; i++) tx_b[i] = 8'(i * 7 + 3);
    tx_b[12] = et[15:8];
    tx_b[13] = et[7:0];
    tx_b[TS_OFS_TB]   = 8'hA8 | {5'b0, ts[18:16]};
    tx_b[TS_OFS_TB+1] = ts[15:8];
    tx_b[TS_OFS_TB+2] = ts[7:0];
    for (int i = 0; i < 8; i++) tx_b[22+i] = cf_old[63-8*i -: 8];
    for (int i = 0; i < 64; i++) exp_b[i] = tx_b[i];
    for (int i = 0; i < 8; i++) exp_b[22+i] = cf_exp[63-8*i -: 8];
  endtask

  // rst_idx = byte index whose cycle pulses i_timer_rst; negative means before the frame
  task automatic send_frame(input int len, input int rst_idx, input bit en_sof,
                            input bit en_after, output int start);
    int pre;
    pre   = (rst_idx < 0) ? -rst_idx : 0;
    start = 0;
    for (int j = -pre; j < len; j++) begin
      @(posedge clk); #1;
      trst = (j == rst_idx);
      if (j < 0) begin
        wr  = 1'b0;
        din = '0;
      end else begin
        wr  = 1'b1;
        din = {(j == 0), tx_b[j]};
        if (j == 0) begin
          start = cyc;
          en    = en_sof;
        end
        if (j == 1) en = en_after;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk); #1;
      wr   = 1'b0;
      din  = '0;
      trst = 1'b0;
    end
  endtask

  task automatic check_frame(input string name, input int start, input int len,
                             input bit edges, input bit use2);
    logic [9:0] got, want;
    int bad;
    bad  = -1;
    got  = '0;
    want = '0;
    for (int i = -1; i <= len; i++) begin
      if (bad < 0 && (edges || (i >= 0 && i < len))) begin
        got  = use2 ? log2[start+9+i] : log1[start+9+i];
        want = (i < 0 || i == len) ? got & 10'h1FF : {1'b1, (i == 0), exp_b[i]};
        if (got !== want) bad = i + 1;
      end
    end
    n_run++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: byte %0d got %0h expected %0h", name, bad - 1, got, want);
    end
  endtask

  initial begin
    int s, s2;
    rst_n = 1'b0; wr = 1'b0; din = '0; trst = 1'b0; en = 1'b0;

    vecs[0] = '{16'h98F7, 19'h00100, 'h300, 64'h0,                   1'b1, 1'b0, 64'h0000_0000_1000_0000, 1, 0};
    vecs[1] = '{16'h98F7, 19'h7A100, 'h010, 64'h1234,                1'b1, 1'b1, 64'h0000_0000_0180_1234, 2, 0};
    vecs[2] = '{16'h0800, 19'h00100, 'h300, 64'h1122_3344_5566_7788, 1'b1, 1'b1, 64'h1122_3344_5566_7788, 2, 0};
    vecs[3] = '{16'h98F7, 19'h00100, 'h300, 64'h1122_3344_5566_7788, 1'b0, 1'b1, 64'h1122_3344_5566_7788, 2, 0};
    vecs[4] = '{16'h98F7, 19'h00123, 'h123, 64'hAB,                  1'b1, 1'b1, 64'hAB,                  3, 0};
    vecs[5] = '{16'h98F7, 19'h00200, 'h201, 64'h0000_FFFF_FFFF_0000, 1'b1, 1'b1, 64'h0001_0000_0007_0000, 4, 0};
    vecs[6] = '{16'h98F8, 19'h00100, 'h300, 64'h55,                  1'b1, 1'b1, 64'h55,                  4, 0};
    vecs[7] = '{16'h98F7, 19'h00000, 'h3E8, 64'h0000_0001_0000_0000, 1'b1, 1'b1, 64'h0000_0001_1F40_0000, 5, 0};

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_wr", 64'(dwr), 64'h0);
    check("rst_out_data", 64'(dout), 64'h0);
    check("rst_upd_cnt", 64'(upd), 64'h0);
    check("rst_err_cnt", 64'(err), 64'h0);
    check("rst_out_wr2", 64'(dwr2), 64'h0);
    rst_n = 1'b1;
    idle(10);

    for (int v = 0; v < 8; v++) begin
      build(vecs[v].etype, vecs[v].ts, vecs[v].cf_old, vecs[v].cf_exp);
      send_frame(40, CF_LAST - 1 - vecs[v].tmr, vecs[v].en_sof, vecs[v].en_after, s);
      idle(12);
      check_frame($sformatf("vec%0d_frame", v), s, 40, 1'b1, 1'b0);
      check($sformatf("vec%0d_upd", v), 64'(upd), 64'(vecs[v].upd));
      check($sformatf("vec%0d_err", v), 64'(err), 64'(vecs[v].err));
    end

    // Frame ends in CF_S with a gap
    build(16'h98F7, 19'h100, 64'h77, 64'h77);
    send_frame(20, 999, 1'b1, 1'b1, s);
    idle(12);
    check_frame("short_gap_frame", s, 20, 1'b1, 1'b0);
    check("short_gap_err", 64'(err), 64'd1);
    check("short_gap_upd", 64'(upd), 64'd5);

    // 25-byte PTP frame cut by a back-to-back frame that must still update
    build(16'h98F7, 19'h100, 64'h99, 64'h99);
    send_frame(25, 999, 1'b1, 1'b1, s);
    build(16'h98F7, 19'h00000, 64'h0, 64'h0000_0000_00A0_0000);
    send_frame(40, CF_LAST - 1 - 20, 1'b1, 1'b1, s2);
    idle(12);
    check_frame("b2b_second_frame", s2, 40, 1'b0, 1'b0);
    build(16'h98F7, 19'h100, 64'h99, 64'h99);
    check_frame("short_sof_frame", s, 25, 1'b0, 1'b0);
    check("short_sof_err", 64'(err), 64'd2);
    check("b2b_upd", 64'(upd), 64'd6);

    // 64-bit carry out of the correctionField
    build(16'h98F7, 19'h00005, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0007_FFFF);
    send_frame(40, CF_LAST - 1 - 6, 1'b1, 1'b1, s);
    idle(12);
    check_frame("carry_dflt_frame", s, 40, 1'b1, 1'b0);
    build(16'h98F7, 19'h00005, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0);
    check_frame("carry_wrap_frame", s, 40, 1'b1, 1'b1);
    check("carry_upd", 64'(upd), 64'd7);

    // Reset mid-frame flushes the delay line
    build(16'h98F7, 19'h100, 64'h0, 64'h0);
    send_frame(15, 999, 1'b1, 1'b1, s);
    @(posedge clk); #1;
    rst_n = 1'b0; wr = 1'b0; din = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    s2 = cyc;
    idle(12);
    begin
      int nvalid;
      nvalid = 0;
      for (int k = 0; k < 9; k++) if (log1[s2+k][9] !== 1'b0) nvalid++;
      check("rst_mid_no_valid", 64'(nvalid), 64'h0);
    end
    check("rst_mid_upd", 64'(upd), 64'h0);
    check("rst_mid_err", 64'(err), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tc_calc_param.md
Name: tc_calc_param

Overview:
- Parametrised successor to the per-port PTP transparent-clock updater in the TSE receive/transmit path.
- Parses a TSNTag-prefixed Ethernet byte stream and recognises PTP frames by EtherType.
- For PTP frames, adds the local residence time, scaled to the correctionField unit, to the 64-bit correctionField in-stream.
- Fixed latency, flag-preserving output, runtime enable, configurable offsets and timer period, statistics counters, and defined abort behaviour for short or gapped frames.

Parameters:
- TIMER_MAX, 19'h7A11F, last value of the local wrap timer; timer modulus is TIMER_MAX+1.
- TS_W, 19, width of the receive timestamp carried in the TSNTag and of the timer.
- TS_OFS, 11, byte index of the MSB byte of the 3-byte receive timestamp. Only the low TS_W-16 bits of that byte are used.
- ETYPE_OFS, 12, byte index of the EtherType MSB.
- ETYPE_VAL, 16'h98F7, EtherType that marks a PTP frame.
- CF_OFS, 22, byte index of the correctionField MSB (8 bytes, big-endian).
- TICK_NS, 8, nanoseconds per timer tick.
- CF_SHIFT, 16, left shift applied to the residence in ns (16 = IEEE 1588 scaled ns).
- CF_ADJ, 0, signed 32-bit constant in ns added to every residence (pipeline compensation).

Ports:
- i_clk  in  1  125 MHz clock
- i_rst_n  in  1  synchronous active-low reset
- iv_pkt_data  in  9  [8]=start-of-frame flag, [7:0]=byte
- i_pkt_data_wr  in  1  byte valid
- ov_pkt_data  out  9  [8]=start-of-frame flag (preserved), [7:0]=byte
- o_pkt_data_wr  out  1  byte valid
- i_timer_rst  in  1  clears local timer to 0
- i_tc_en  in  1  update enable, sampled at start-of-frame
- ov_tc_upd_cnt  out  32  frames whose correctionField was updated
- ov_tc_err_cnt  out  32  frames aborted (short or gapped)

Behaviour:
- Reset: all outputs 0, timer 0, delay line cleared, FSM in IDLE_S.
- Timer: increments every cycle. Wraps TIMER_MAX -> 0. i_timer_rst has priority over the wrap.
- Delay line: 9 stages of {wr, data[8:0]}, shifting every cycle. Output equals input delayed exactly 9 cycles, with valid and flag bits preserved, for every frame.
- Byte counter: cleared when a byte is accepted with wr=1 and flag=1; increments on each wr=1 byte. Saturates at 127.
- FSM states:
  - IDLE_S: wait for wr=1 with flag=1 -> HDR_S. Latch en_r from i_tc_en.
  - HDR_S: capture timestamp bytes at TS_OFS..TS_OFS+2.
    - Compare bytes ETYPE_OFS..+1 with ETYPE_VAL.
    - Match and en_r -> CF_S. Mismatch -> PASS_S.
  - CF_S: on arrival of byte CF_OFS+7, all 8 CF bytes are in the delay line. That cycle:
    - res = (timer >= ts) ? timer - ts : timer + TIMER_MAX + 1 - ts, computed in TS_W+1 bits.
    - cf_new = cf_old + ((res*TICK_NS + CF_ADJ) << CF_SHIFT), modulo 2^64, with a signed term.
    - Write cf_new bytes into the 8 delay stages, overwriting the data only.
    - Increment ov_tc_upd_cnt. Go to PASS_S.
  - PASS_S: forward until wr=0 -> IDLE_S. A new flag=1 byte starts a new frame directly (HDR_S).
- Abort: in HDR_S or CF_S, wr=0 or a new flag=1 byte before the required bytes are seen means:
  - no modification;
  - ov_tc_err_cnt +1;
  - on wr=0 -> IDLE_S; on a new flag -> restart in HDR_S.
- Timestamp equal to the timer gives res=0. A timestamp greater than TIMER_MAX is treated by the same formula, with no special case.
- Counters wrap at 2^32.
- Reset mid-frame: the delay line is flushed. Partial output is dropped with no valid bytes for 9 cycles after reset release.

Decomposition:
- Package tc_pkg: ETYPE_PTP, default offsets, FSM state encoding, CF_BYTES=8, LAT=9.
- Sub-module tc_residence_calc: combinational wrap-aware subtract, scale and shift, 64-bit add. Reused by future egress timestamp blocks.

Test Plan:
- PTP frame, ts=0x00100, timer=0x00300 at the CF byte, cf_old=0, defaults -> cf_new = (0x200*8)<<16 = 0x0000_0000_1000_0000; output exactly 9 cycles after input; upd_cnt=1.
- Wrap: ts=0x7A100, timer=0x00010 -> res = 0x10 + 0x7A120 - 0x7A100 = 0x30; cf = old + (0x180<<16).
- Non-PTP EtherType 0x0800 -> output byte-identical to input at +9 cycles, counters unchanged.
- i_tc_en=0 on a PTP frame -> unmodified; i_tc_en toggled mid-frame has no effect on the current frame.
- Frame of 25 bytes with EtherType 0x98F7 (ends before CF) -> unmodified, err_cnt=1. A back-to-back frame starting one cycle after the last byte is then processed normally.
- Carry: cf_old = 0xFFFF_FFFF_FFFF_FFFF, res=1, TICK_NS=1, CF_SHIFT=0 -> cf_new = 0; i_timer_rst pulse with TIMER_MAX reached in the same cycle -> timer=0.
